// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters feeding a 4:1 mux select.
// A grant is held for at least DWELL cycles before done or a dropped request can release it.
//
//   state | meaning
//   IDLE  | no grant active; gnt=0, select holds the last index
//   GRANT | one channel owns the mux; cnt counts cycles held
module mux4_rr_arbiter #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid
);

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] sel, sel_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] gnt_next;
    logic [1:0] pick;
    logic       pick_ok;
    logic       release_now;
    logic       take_grant;

    // Search ptr+1 .. ptr+4; the last candidate is ptr itself, so the
    // current grantee only wins again when it is the sole requester.
    always_comb begin : rr_search
        logic [1:0] cand;
        pick    = ptr;
        pick_ok = 1'b0;
        cand    = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!pick_ok && req[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    // In GRANT, ptr always equals the grantee index.
    assign release_now = (state == GRANT) && (cnt == CNT_LAST) && (done || !req[ptr]);
    assign take_grant  = ((state == IDLE) || release_now) && pick_ok;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        cnt_next   = cnt;
        gnt_next   = gnt;
        if (take_grant) begin
            state_next = GRANT;
            ptr_next   = pick;
            sel_next   = pick;
            cnt_next   = 4'd0;
            gnt_next   = 4'b0001 << pick;
        end else if (release_now) begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
        end else if ((state == GRANT) && (cnt != CNT_LAST)) begin
            cnt_next = cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd3;
            sel   <= 2'd0;
            cnt   <= 4'd0;
            gnt   <= 4'b0000;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel   <= sel_next;
            cnt   <= cnt_next;
            gnt   <= gnt_next;
        end
    end

    assign s1    = sel[1];
    assign s0    = sel[0];
    assign valid = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, a between-edge glitch
// sequence, then random traffic against an owner/age reference model.
module tb_mux4_rr_arbiter;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       valid;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.DWELL(DWELL)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .done (done),
        .gnt  (gnt),
        .s1   (s1),
        .s0   (s0),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the mux, who was last served, how many
    // cycles the current owner has been visible.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_age   = 0;

    function automatic int rr_find(logic [3:0] r, int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [3:0] r_req, input logic r_done);
        int n;
        if (r_rst) begin
            m_owner = -1;
            m_last  = 3;
            m_sel   = 0;
            m_age   = 0;
        end else if (m_owner < 0) begin
            n = rr_find(r_req, m_last);
            if (n >= 0) begin
                m_owner = n; m_last = n; m_sel = n; m_age = 1;
            end
        end else if (m_age >= DWELL && (r_done || !r_req[m_owner])) begin
            n = rr_find(r_req, m_last);
            if (n >= 0) begin
                m_owner = n; m_last = n; m_sel = n; m_age = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        logic       sr;
        logic [3:0] sq;
        logic       sd;
        @(posedge clk);
        sr = rst; sq = req; sd = done;
        model_step(sr, sq, sd);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] q, logic d, logic [3:0] g, logic [1:0] s);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.gnt = g; v.sel = s;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0] one;
        logic [3:0] m_gnt;
        one  = 4'b0001;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // reset with all requesting, then full rotation
        add(1, 4'hF, 1, 4'h0, 2'd0);
        add(1, 4'hF, 1, 4'h0, 2'd0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < DWELL; c++)
                add(0, 4'hF, 1, one << (r % 4), 2'(r % 4));
        // single request, dropped before the release edge
        add(1, 4'h0, 1, 4'h0, 2'd0);
        for (int c = 0; c < DWELL; c++) add(0, 4'h4, 1, 4'h4, 2'd2);
        add(0, 4'h0, 1, 4'h0, 2'd2);
        add(0, 4'h0, 1, 4'h0, 2'd2);
        // early drop is ignored until dwell expires
        add(0, 4'h2, 0, 4'h2, 2'd1);
        for (int c = 1; c < DWELL; c++) add(0, 4'h0, 0, 4'h2, 2'd1);
        add(0, 4'h0, 0, 4'h0, 2'd1);
        // reset mid-grant
        add(0, 4'h4, 1, 4'h4, 2'd2);
        add(0, 4'h4, 1, 4'h4, 2'd2);
        add(1, 4'hF, 1, 4'h0, 2'd0);
        add(0, 4'hF, 1, 4'h1, 2'd0);
        // wrap 3 -> 0 back-to-back
        add(1, 4'h0, 0, 4'h0, 2'd0);
        for (int c = 0; c < DWELL; c++) add(0, 4'h8, 0, 4'h8, 2'd3);
        add(0, 4'h9, 1, 4'h1, 2'd0);
        // sole requester re-granted, then held past dwell, then dropped
        for (int c = 1; c < DWELL; c++) add(0, 4'h1, 1, 4'h1, 2'd0);
        add(0, 4'h1, 1, 4'h1, 2'd0);
        for (int c = 0; c < 6; c++) add(0, 4'h1, 0, 4'h1, 2'd0);
        add(0, 4'h0, 0, 4'h0, 2'd0);

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            check($sformatf("vec%0d gnt", i), gnt, tbl[i].gnt);
            check($sformatf("vec%0d sel", i), {2'b00, s1, s0}, {2'b00, tbl[i].sel});
            check($sformatf("vec%0d valid", i), {3'b000, valid}, {3'b000, (tbl[i].gnt != 4'h0)});
        end

        // a request pulse that never sees an edge must not grant
        req = 4'b0010;
        #2;
        req = 4'b0000;
        tick();
        check("glitch gnt", gnt, 4'h0);
        check("glitch valid", {3'b000, valid}, 4'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            tick();
            m_gnt = (m_owner < 0) ? 4'h0 : (one << m_owner);
            check($sformatf("rand%0d gnt", i), gnt, m_gnt);
            check($sformatf("rand%0d sel", i), {2'b00, s1, s0}, 4'(m_sel));
            check($sformatf("rand%0d valid", i), {3'b000, valid}, {3'b000, (m_owner >= 0)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
